// File: rtl/pitch_detector.sv
// Zero-crossing pitch detector: period count divided into 2^P gives a phase increment.
// Optional macro PITCH_DETECTOR_AVERAGE_EN averages the last two periods.
`timescale 1ns/1ps

module pitch_detector #(
   parameter int BITDEPTH    = 14,
   parameter int BITFRACTION = 6,
   parameter int HYST        = 256
) (
   input  logic                sample_clock,
   input  logic                rst_n,
   input  logic                sample_valid,
   input  logic [BITDEPTH-1:0] sample_in,
   output logic [15:0]         increment,
   output logic                increment_valid,
   output logic                locked,
   output logic                busy
);

   localparam int P   = BITDEPTH + BITFRACTION;
`ifdef PITCH_DETECTOR_AVERAGE_EN
   localparam int DW  = 17;
   localparam int NB  = P + 2;
`else
   localparam int DW  = 16;
   localparam int NB  = P + 1;
`endif
   localparam int SW  = $clog2(NB);
   localparam int MID = (2 ** (BITDEPTH - 1)) - 1;
   localparam logic [BITDEPTH-1:0] LO = BITDEPTH'(MID - HYST);
   localparam logic [BITDEPTH-1:0] HI = BITDEPTH'(MID + HYST);

   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

   state_t          r_state, w_next;
   logic [15:0]     r_cnt, w_cnt_inc, w_quo_sat;
   logic            r_armed, r_seen, r_one_done;
   logic            w_cross, w_timeout, w_start, w_ge;
   logic [DW-1:0]   r_div, r_rem, w_divisor, w_diff;
   logic [DW:0]     w_trial;
   logic [NB-1:0]   r_quo;
   logic [SW-1:0]   r_step;

   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 16'd1;
   assign w_cross   = sample_valid && r_armed && (sample_in > HI);
   // timeout fires only on the transition into saturation
   assign w_timeout = sample_valid && !w_cross && (r_cnt == 16'hFFFE);

`ifdef PITCH_DETECTOR_AVERAGE_EN
   logic [15:0] r_prev;
   logic        r_have;

   assign w_divisor = {1'b0, r_prev} + {1'b0, w_cnt_inc};
   assign w_start   = w_cross && r_seen && r_have && (r_state == IDLE);

   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= '0;
         r_have <= 1'b0;
      end else if (w_timeout) begin
         r_have <= 1'b0;
      end else if (w_cross && r_seen) begin
         r_prev <= w_cnt_inc;
         r_have <= 1'b1;
      end
   end
`else
   assign w_divisor = w_cnt_inc;
   assign w_start   = w_cross && r_seen && (r_state == IDLE);
`endif

   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
         r_seen  <= 1'b0;
      end else if (sample_valid) begin
         r_cnt <= w_cross ? '0 : w_cnt_inc;
         if (w_timeout) begin
            r_armed <= 1'b0;
            r_seen  <= 1'b0;
         end else if (w_cross) begin
            r_armed <= 1'b0;
            r_seen  <= 1'b1;
         end else if (sample_in < LO) begin
            r_armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      unique case (r_state)
         IDLE:   if (w_start) w_next = DIVIDE;
         DIVIDE: begin
            busy = 1'b1;
            if (r_step == SW'(NB - 1)) w_next = DONE;
         end
         DONE: begin
            busy   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // dividend is a single 1 at its MSB, so only the first step shifts in a 1
   assign w_trial   = {r_rem, (r_step == '0)};
   assign w_ge      = w_trial >= {1'b0, r_div};
   assign w_diff    = w_trial[DW-1:0] - r_div;
   assign w_quo_sat = (|r_quo[NB-1:16]) ? 16'hFFFF : r_quo[15:0];

   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_step <= '0;
      end else if (w_start) begin
         r_div  <= w_divisor;
         r_rem  <= '0;
         r_quo  <= '0;
         r_step <= '0;
      end else if (r_state == DIVIDE) begin
         r_rem  <= w_ge ? w_diff : w_trial[DW-1:0];
         r_quo  <= {r_quo[NB-2:0], w_ge};
         r_step <= r_step + SW'(1);
      end
   end

   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         increment       <= '0;
         increment_valid <= 1'b0;
         locked          <= 1'b0;
         r_one_done      <= 1'b0;
      end else begin
         increment_valid <= (r_state == DONE);
         if (r_state == DONE) increment <= w_quo_sat;
         if (w_timeout) begin
            locked     <= 1'b0;
            r_one_done <= 1'b0;
         end else if (r_state == DONE) begin
            locked     <= locked | r_one_done;
            r_one_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pitch_detector.sv
// Directed bench for pitch_detector with a sample-level reference model
// feeding a scoreboard of expected increment pulses.
`timescale 1ns/1ps

module tb_pitch_detector;

   localparam int P = 20;
`ifdef PITCH_DETECTOR_AVERAGE_EN
   localparam bit AVG = 1'b1;
   localparam int NB  = P + 2;
`else
   localparam bit AVG = 1'b0;
   localparam int NB  = P + 1;
`endif
   localparam int LO  = 7935;
   localparam int HI  = 8447;
   localparam int MID = 8191;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [13:0] sample_in = '0;
   logic [15:0] increment;
   logic        increment_valid, locked, busy;

   always #5 clk = ~clk;

   pitch_detector dut (
      .sample_clock    (clk),
      .rst_n           (rst_n),
      .sample_valid    (sample_valid),
      .sample_in       (sample_in),
      .increment       (increment),
      .increment_valid (increment_valid),
      .locked          (locked),
      .busy            (busy)
   );

   typedef struct {
      logic [15:0] inc;
      logic        lck;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   bit          m_armed, m_seen, m_have, m_one, m_locked;
   int          m_cnt, m_prev, m_start;
   logic [15:0] m_inc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] quot(input longint num, input longint den);
      longint q;
      q = num / den;
      return (q > 65535) ? 16'hFFFF : 16'(q);
   endfunction

   task automatic model_reset;
      m_armed  = 0;
      m_seen   = 0;
      m_have   = 0;
      m_one    = 0;
      m_locked = 0;
      m_cnt    = 0;
      m_prev   = 0;
      m_start  = -1000;
      m_inc    = '0;
      sb.delete();
   endtask

   // drive one valid sample (called at a negedge) and advance the model
   task automatic put(input int s, input int gap);
      int   edge_i, inc, div;
      bit   ready;
      longint num;
      exp_t e;
      sample_valid = 1'b1;
      sample_in    = 14'(s);
      edge_i = cyc + 1;
      inc = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      if (m_armed && s > HI) begin
         if (m_seen) begin
            ready = 1;
            div   = inc;
            num   = 64'd1 << P;
            if (AVG) begin
               ready  = m_have;
               div    = m_prev + inc;
               num    = 64'd1 << (P + 1);
               m_prev = inc;
               m_have = 1;
            end
            if (ready && (edge_i - m_start >= NB + 2)) begin
               m_locked = m_locked | m_one;
               m_one    = 1;
               e.inc    = quot(num, longint'(div));
               e.lck    = m_locked;
               e.cyc    = edge_i + NB + 1;
               m_inc    = e.inc;
               m_start  = edge_i;
               sb.push_back(e);
            end
         end
         m_seen  = 1;
         m_armed = 0;
         m_cnt   = 0;
      end else begin
         if (m_cnt == 65534) begin
            m_armed  = 0;
            m_seen   = 0;
            m_have   = 0;
            m_one    = 0;
            m_locked = 0;
         end else if (s < LO) begin
            m_armed = 1;
         end
         m_cnt = inc;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic square(input int half, input int nper, input int gap);
      for (int p = 0; p < nper; p++) begin
         for (int k = 0; k < half; k++) put(0, gap);
         for (int k = 0; k < half; k++) put(16383, gap);
      end
   endtask

   task automatic drain;
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && increment_valid) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_pulse: observed increment %0d expected no pulse",
                   increment);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("inc_value", increment, e.inc);
            check("inc_locked", locked, e.lck);
            check("inc_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [19:0] ph;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_increment", increment, 0);
      check("rst_valid", increment_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // oscillator sawtooth, step 1024, one sample every 4 clocks
      ph = '0;
      for (int k = 0; k < 2600; k++) begin
         put(int'(ph[19:6]), 3);
         ph = ph + 20'd1024;
      end
      drain();
      check("saw_inc", increment, 1024);
      check("saw_locked", locked, 32'(!AVG));

      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      square(50, 5, 0);
      drain();
      check("sq100_inc", increment, 10485);
      check("sq100_locked", locked, 1);

      square(5, 6, 2);
      drain();
      check("sq10_inc", increment, 16'hFFFF);

      // crossings every 8 clocks: those landing while busy are dropped
      square(4, 8, 0);
      drain();
      check("sq8_inc", increment, 16'hFFFF);
      check("sq8_locked", locked, 1);

      while (m_cnt != 65534) put(MID, 0);
      check("pre_timeout_locked", locked, 1);
      put(MID, 0);
      check("timeout_locked", locked, 0);
      check("timeout_inc_held", increment, 16'hFFFF);
      check("timeout_busy", busy, 0);
      drain();

      square(50, 4, 0);
      drain();
      check("relock_inc", increment, 10485);
      check("relock_locked", locked, 1);

      for (int k = 0; k < 50; k++) put(0, 0);
      put(16383, 0);
      check("mid_div_started", sb.size(), 1);
      repeat (4) @(negedge clk);
      check("mid_div_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_increment", increment, 0);
      check("abort_valid", increment_valid, 0);
      check("abort_locked", locked, 0);
      check("abort_busy", busy, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      square(50, 3, 0);
      drain();
      check("post_abort_inc", increment, 10485);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
